proc_run_ctrl: RTL
==================

Name: proc_run_ctrl

Overview:
Synthesizable run controller for one or more processor cores.
- On start, it waits a settling interval and pulses the cores' reset.
- It then lets the cores run for a programmable cycle budget and watches each core's dmem write port for a completion signature (address/data match).
- It reports per-core completion, timeout and abort status.
- It sits between the top-level/bench control and the processor instances, replacing open-loop reset/run/stop sequencing.

Parameters:
NUM_CORES, 1, number of processor instances controlled/monitored
ADDR_W, 12, dmem address width per core
DATA_W, 32, dmem data width per core
CNT_W, 16, width of run budget and cycle counter
PRE_CYCLES, 4, settling cycles before reset pulse (0 = skip)
RESET_CYCLES, 1, core reset pulse length in cycles (must be >= 1)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low block reset
start  in  1  begin a run (sampled only in IDLE)
abort  in  1  terminate current run
run_cycles  in  CNT_W  RUN budget in cycles, latched at start; 0 = unbounded
watch_addr  in  ADDR_W  signature address, latched at start
watch_data  in  DATA_W  signature data, latched at start
dmem_wren  in  NUM_CORES  per-core dmem write enable
dmem_address  in  NUM_CORES*ADDR_W  per-core dmem address, core i at [i*ADDR_W +: ADDR_W]
dmem_data_in  in  NUM_CORES*DATA_W  per-core dmem write data, same packing
core_reset  out  NUM_CORES  active-high reset to each core
busy  out  1  high in PRE, RESET, RUN
done  out  1  one-cycle pulse on run completion
hit_mask  out  NUM_CORES  sticky per-core signature seen
timeout  out  1  budget expired before all cores hit
aborted  out  1  run ended by abort
cycle_count  out  CNT_W  RUN cycles elapsed, saturates at all-ones

Behaviour:
- Reset values (reset==0 at a clock edge):
  - State IDLE.
  - core_reset all ones.
  - busy, done, timeout and aborted 0.
  - hit_mask 0, cycle_count 0, latched config 0.
- State machine: IDLE -> PRE -> RESET -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 latches run_cycles, watch_addr and watch_data.
  - It clears hit_mask, timeout, aborted and cycle_count.
  - Next state is PRE, or RESET if PRE_CYCLES=0.
- PRE lasts exactly PRE_CYCLES cycles; RESET lasts exactly RESET_CYCLES cycles.
- Start latency: start high in IDLE at cycle T puts the first RUN cycle at T+1+PRE_CYCLES+RESET_CYCLES.
- core_reset is all zeros only in RUN and all ones in every other state.
- RUN:
  - cycle_count increments each cycle, saturating.
  - Core i hits when dmem_wren[i]=1, its address equals watch_addr and its data equals watch_data.
  - A hit sets hit_mask[i], which stays set until the next accepted start.
  - Exit to DONE on the cycle where (hit_mask | new hits) becomes all ones; timeout=0.
  - Budget exit: with run_cycles=N>0, RUN lasts at most N cycles. If not all hit after the Nth cycle, exit to DONE with timeout=1.
  - A final hit in the Nth cycle counts as success; timeout=0.
  - run_cycles=0: no budget; exit only on all-hit or abort.
- abort=1 in PRE, RESET or RUN:
  - Next state is DONE and aborted=1. Abort takes priority over all-hit or timeout in the same cycle.
  - hit_mask keeps its value, including hits in that cycle.
  - core_reset reasserts on the next cycle.
  - abort in IDLE or DONE is ignored.
- DONE:
  - Lasts one cycle; done=1 there, then IDLE.
  - hit_mask, timeout, aborted and cycle_count hold until the next accepted start.
- Ignored inputs: start outside IDLE, and dmem inputs outside RUN.
- Reset mid-run: on any reset==0 edge, all state returns to reset values immediately. No done pulse is issued.
- All comparisons are full-width equality.

Test Plan:
- NUM_CORES=1, PRE=4, RESET=1, run_cycles=10, start pulse at cycle 0, no writes:
  - core_reset low cycles 6-15.
  - done at cycle 16; timeout=1, cycle_count=10, hit_mask=0.
- NUM_CORES=2, watch 0x0FF/0xDEADBEEF, budget 100:
  - Core0 matching write at RUN cycle 3, core1 at RUN cycle 7.
  - hit_mask=01 then 11; done the cycle after RUN cycle 7; timeout=0, cycle_count=7.
- Budget 5, matching write on the 5th RUN cycle -> done, timeout=0, hit_mask=1.
- Near-miss writes with data 0xDEADBEEE, then wren=0 with matching addr/data -> no hit bits set.
- Abort raised in RESET, and separately in the same RUN cycle as the final hit -> next state DONE, aborted=1, timeout=0, core_reset back to all ones.
- Reset=0 at RUN cycle 2 -> next cycle core_reset all ones, busy=0, cycle_count=0, no done pulse. Start during busy -> no restart, latched config unchanged.

Source files
------------

// File: rtl/proc_run_ctrl.sv
// Run controller: settles, pulses core reset, then runs the cores against a cycle
// budget while watching each core's dmem write port for a completion signature.
module proc_run_ctrl #(
   parameter int unsigned NUM_CORES    = 1,
   parameter int unsigned ADDR_W       = 12,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned PRE_CYCLES   = 4,
   parameter int unsigned RESET_CYCLES = 1
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        abort,
   input  logic [CNT_W-1:0]            run_cycles,
   input  logic [ADDR_W-1:0]           watch_addr,
   input  logic [DATA_W-1:0]           watch_data,
   input  logic [NUM_CORES-1:0]        dmem_wren,
   input  logic [NUM_CORES*ADDR_W-1:0] dmem_address,
   input  logic [NUM_CORES*DATA_W-1:0] dmem_data_in,
   output logic [NUM_CORES-1:0]        core_reset,
   output logic                        busy,
   output logic                        done,
   output logic [NUM_CORES-1:0]        hit_mask,
   output logic                        timeout,
   output logic                        aborted,
   output logic [CNT_W-1:0]            cycle_count
);

   localparam int unsigned PH_MAX   = (PRE_CYCLES > RESET_CYCLES) ? PRE_CYCLES : RESET_CYCLES;
   localparam int unsigned PH_W     = $clog2(PH_MAX + 1);
   localparam int unsigned PRE_LAST = (PRE_CYCLES > 0) ? PRE_CYCLES - 1 : 0;
   localparam int unsigned RST_LAST = (RESET_CYCLES > 0) ? RESET_CYCLES - 1 : 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_RESET,
      S_RUN,
      S_DONE
   } state_t;

   typedef struct packed {
      logic [CNT_W-1:0]  budget;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } cfg_t;

   state_t                 state_q, state_d;
   logic [PH_W-1:0]        phase_q, phase_d;
   cfg_t                   cfg_q, cfg_d;
   logic [NUM_CORES-1:0]   new_hit, hits_all, hit_d;
   logic                   timeout_d, aborted_d;
   logic [CNT_W-1:0]       count_d;

   // Per-core signature match against the latched watch address/data
   always_comb begin
      new_hit = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         new_hit[i] = dmem_wren[i]
                    && (dmem_address[i*ADDR_W +: ADDR_W] == cfg_q.addr)
                    && (dmem_data_in[i*DATA_W +: DATA_W] == cfg_q.data);
      end
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      cfg_d     = cfg_q;
      hit_d     = hit_mask;
      timeout_d = timeout;
      aborted_d = aborted;
      count_d   = cycle_count;
      hits_all  = hit_mask | new_hit;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cfg_d     = '{budget: run_cycles, addr: watch_addr, data: watch_data};
               hit_d     = '0;
               timeout_d = 1'b0;
               aborted_d = 1'b0;
               count_d   = '0;
               phase_d   = '0;
               state_d   = (PRE_CYCLES == 0) ? S_RESET : S_PRE;
            end
         end
         S_PRE: begin
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = S_DONE;
            end else if (phase_q == PH_W'(PRE_LAST)) begin
               phase_d = '0;
               state_d = S_RESET;
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         S_RESET: begin
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = S_DONE;
            end else if (phase_q == PH_W'(RST_LAST)) begin
               phase_d = '0;
               state_d = S_RUN;
            end else begin
               phase_d = phase_q + PH_W'(1);
            end
         end
         S_RUN: begin
            hit_d   = hits_all;
            count_d = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
            // Abort outranks completion, and completion outranks budget expiry
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = S_DONE;
            end else if (&hits_all) begin
               state_d = S_DONE;
            end else if ((cfg_q.budget != '0) && (count_d == cfg_q.budget)) begin
               timeout_d = 1'b1;
               state_d   = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they align with the state register
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         phase_q     <= '0;
         cfg_q       <= '0;
         core_reset  <= '1;
         busy        <= 1'b0;
         done        <= 1'b0;
         hit_mask    <= '0;
         timeout     <= 1'b0;
         aborted     <= 1'b0;
         cycle_count <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         cfg_q       <= cfg_d;
         core_reset  <= {NUM_CORES{state_d != S_RUN}};
         busy        <= (state_d == S_PRE) || (state_d == S_RESET) || (state_d == S_RUN);
         done        <= (state_d == S_DONE);
         hit_mask    <= hit_d;
         timeout     <= timeout_d;
         aborted     <= aborted_d;
         cycle_count <= count_d;
      end
   end

endmodule
